// File: rtl/cpu_loader_pkg.sv
// Shared definitions for the UART instruction loader.
// Provides the loader state encoding, the instruction word type and
// the default download terminator word.
package cpu_loader_pkg;

  localparam int unsigned INST_W = 16;
  localparam int unsigned BYTE_W = 8;

  localparam logic [INST_W-1:0] LOADER_END_WORD = 16'hFFFF;

  typedef logic [INST_W-1:0] inst_t;
  typedef logic [BYTE_W-1:0] rx_byte_t;

  typedef enum logic [1:0] {
    S_HI   = 2'd0,
    S_LO   = 2'd1,
    S_DONE = 2'd2
  } loader_state_t;

  // Width of a counter that must hold 0..max_inst inclusive.
  function automatic int unsigned count_width(input int unsigned max_inst);
    return (max_inst > 0) ? $clog2(max_inst + 1) : 1;
  endfunction

endpackage

// File: rtl/uart_inst_loader_if.sv
// Bus between the UART RX / download controller side and the loader.
// master: byte source side (drives rx_data, rx_valid, rx_err, reload).
// slave : the loader (drives uart_inst, uart_inst_en, done, enable,
//         inst_count, err).
interface uart_inst_loader_if #(
  parameter int unsigned MAX_INST = 256
);
  import cpu_loader_pkg::*;

  localparam int unsigned CNT_W = count_width(MAX_INST);

  rx_byte_t         rx_data;
  logic             rx_valid;
  logic             rx_err;
  logic             reload;
  inst_t            uart_inst;
  logic             uart_inst_en;
  logic             done;
  logic             enable;
  logic [CNT_W-1:0] inst_count;
  logic             err;

  modport master (
    output rx_data, rx_valid, rx_err, reload,
    input  uart_inst, uart_inst_en, done, enable, inst_count, err
  );

  modport slave (
    input  rx_data, rx_valid, rx_err, reload,
    output uart_inst, uart_inst_en, done, enable, inst_count, err
  );

endinterface

// File: rtl/loader_timeout.sv
// Inter-byte timeout: loadable down-counter.
// Ports: clk, reset (sync, active-low), load (reload to BYTE_TIMEOUT-1),
//        run (count down while waiting for a low byte),
//        expire_c (combinational, counter has reached zero).
module loader_timeout #(
  parameter int unsigned BYTE_TIMEOUT = 100000
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic run,
  output logic expire_c
);

  localparam int unsigned TW = (BYTE_TIMEOUT > 1) ? $clog2(BYTE_TIMEOUT) : 1;
  localparam logic [TW-1:0] LOAD_VAL = TW'(BYTE_TIMEOUT - 1);

  logic [TW-1:0] cnt_q;

  // Down-count from BYTE_TIMEOUT-1; zero marks the last cycle a low byte may arrive.
  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= LOAD_VAL;
    end else if (run && (cnt_q != '0)) begin
      cnt_q <= cnt_q - TW'(1);
    end
  end

  assign expire_c = (cnt_q == '0);

endmodule

// File: rtl/uart_inst_loader.sv
// Assembles 16-bit instructions (high byte first) from the UART RX byte
// stream and hands them to the fetch stage; raises the CPU run enable
// once the download ends (terminator word or MAX_INST words).
// Ports: clk, reset (sync, active-low), bus (slave side of
//        uart_inst_loader_if: rx_data/rx_valid/rx_err/reload in,
//        uart_inst/uart_inst_en/done/enable/inst_count/err out).
module uart_inst_loader
  import cpu_loader_pkg::*;
#(
  parameter int unsigned  MAX_INST     = 256,
  parameter logic [INST_W-1:0] END_WORD = LOADER_END_WORD,
  parameter int unsigned  BYTE_TIMEOUT = 100000
) (
  input logic              clk,
  input logic              reset,
  uart_inst_loader_if.slave bus
);

  localparam int unsigned CNT_W = count_width(MAX_INST);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_INST);

  loader_state_t    state, next_state;

  rx_byte_t         hi_q, hi_d;
  inst_t            inst_q, inst_d;
  logic             inst_en_q, inst_en_d;
  logic             done_q, done_d;
  logic             enable_q, enable_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             err_q, err_d;

  logic             byte_ok_c;
  inst_t            word_c;
  logic [CNT_W-1:0] count_inc_c;
  logic             to_load_c;
  logic             to_expire_c;

  assign byte_ok_c   = bus.rx_valid && !bus.rx_err;
  assign word_c      = {hi_q, bus.rx_data};
  assign count_inc_c = (count_q == CNT_MAX) ? count_q : count_q + CNT_W'(1);

  loader_timeout #(
    .BYTE_TIMEOUT (BYTE_TIMEOUT)
  ) u_timeout (
    .clk      (clk),
    .reset    (reset),
    .load     (to_load_c),
    .run      (state == S_LO),
    .expire_c (to_expire_c)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= S_HI;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic; an error strobe always beats a simultaneous byte.
  always_comb begin
    next_state = state;
    case (state)
      S_HI: begin
        if (byte_ok_c) next_state = S_LO;
      end
      S_LO: begin
        if (bus.rx_err) begin
          next_state = S_HI;
        end else if (bus.rx_valid) begin
          if ((word_c == END_WORD) || (count_inc_c == CNT_MAX)) begin
            next_state = S_DONE;
          end else begin
            next_state = S_HI;
          end
        end else if (to_expire_c) begin
          next_state = S_HI;
        end
      end
      S_DONE: begin
        if (bus.reload) next_state = S_HI;
      end
      default: next_state = S_HI;
    endcase
  end

  // Output / datapath next values.
  always_comb begin
    hi_d      = hi_q;
    inst_d    = inst_q;
    inst_en_d = 1'b0;
    count_d   = count_q;
    err_d     = err_q;
    to_load_c = 1'b0;
    case (state)
      S_HI: begin
        if (bus.rx_err) begin
          err_d = 1'b1;
        end else if (bus.rx_valid) begin
          hi_d      = bus.rx_data;
          to_load_c = 1'b1;
        end
      end
      S_LO: begin
        if (bus.rx_err) begin
          err_d = 1'b1;
        end else if (bus.rx_valid) begin
          // Terminator is consumed silently.
          if (word_c != END_WORD) begin
            inst_d    = word_c;
            inst_en_d = 1'b1;
            count_d   = count_inc_c;
          end
        end else if (to_expire_c) begin
          err_d = 1'b1;
        end
      end
      S_DONE: begin
        if (bus.reload) begin
          count_d = '0;
          err_d   = 1'b0;
        end
      end
      default: ;
    endcase
    done_d   = (next_state == S_DONE) && (state != S_DONE);
    enable_d = (next_state == S_DONE);
  end

  // Registered outputs and high-byte holding register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      hi_q      <= '0;
      inst_q    <= '0;
      inst_en_q <= 1'b0;
      done_q    <= 1'b0;
      enable_q  <= 1'b0;
      count_q   <= '0;
      err_q     <= 1'b0;
    end else begin
      hi_q      <= hi_d;
      inst_q    <= inst_d;
      inst_en_q <= inst_en_d;
      done_q    <= done_d;
      enable_q  <= enable_d;
      count_q   <= count_d;
      err_q     <= err_d;
    end
  end

  assign bus.uart_inst    = inst_q;
  assign bus.uart_inst_en = inst_en_q;
  assign bus.done         = done_q;
  assign bus.enable       = enable_q;
  assign bus.inst_count   = count_q;
  assign bus.err          = err_q;

endmodule

// File: tb/tb_uart_inst_loader.sv
// Directed testbench for uart_inst_loader (MAX_INST=4, BYTE_TIMEOUT=50).
module tb_uart_inst_loader;
  import cpu_loader_pkg::*;

  localparam int unsigned MAX_INST     = 4;
  localparam int unsigned BYTE_TIMEOUT = 50;

  logic clk = 1'b0;
  logic reset = 1'b0;

  always #5 clk = ~clk;

  uart_inst_loader_if #(.MAX_INST(MAX_INST)) bus ();

  uart_inst_loader #(
    .MAX_INST     (MAX_INST),
    .END_WORD     (16'hFFFF),
    .BYTE_TIMEOUT (BYTE_TIMEOUT)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [7:0]  hi;
    logic [7:0]  lo;
    int          gap;
    logic        en;
    logic [15:0] inst;
    logic        done;
    logic        enable;
    logic [2:0]  cnt;
    logic        err;
  } vec_t;

  vec_t vecs [3];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic check_outs(input string tag, input logic en, input logic [15:0] inst,
                            input logic dn, input logic ena, input logic [2:0] cnt,
                            input logic er);
    check({tag, ".uart_inst_en"}, 32'(bus.uart_inst_en), 32'(en));
    check({tag, ".uart_inst"},    32'(bus.uart_inst),    32'(inst));
    check({tag, ".done"},         32'(bus.done),         32'(dn));
    check({tag, ".enable"},       32'(bus.enable),       32'(ena));
    check({tag, ".inst_count"},   32'(bus.inst_count),   32'(cnt));
    check({tag, ".err"},          32'(bus.err),          32'(er));
  endtask

  // Advance one clock; outputs are then stable for sampling.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic send_byte(input logic [7:0] b, input logic e);
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    bus.rx_err   = e;
    step();
    bus.rx_valid = 1'b0;
    bus.rx_err   = 1'b0;
  endtask

  task automatic pulse_reload();
    bus.reload = 1'b1;
    step();
    bus.reload = 1'b0;
  endtask

  initial begin
    logic [15:0] w;
    logic [15:0] last_w;

    vecs[0] = '{hi: 8'h12, lo: 8'h34, gap: 10, en: 1'b1, inst: 16'h1234, done: 1'b0, enable: 1'b0, cnt: 3'd1, err: 1'b0};
    vecs[1] = '{hi: 8'hAB, lo: 8'hCD, gap: 10, en: 1'b1, inst: 16'hABCD, done: 1'b0, enable: 1'b0, cnt: 3'd2, err: 1'b0};
    vecs[2] = '{hi: 8'hFF, lo: 8'hFF, gap: 10, en: 1'b0, inst: 16'hABCD, done: 1'b1, enable: 1'b1, cnt: 3'd2, err: 1'b0};

    bus.rx_data  = 8'h00;
    bus.rx_valid = 1'b0;
    bus.rx_err   = 1'b0;
    bus.reload   = 1'b0;
    reset        = 1'b0;
    idle(2);
    reset = 1'b1;
    check_outs("reset", 1'b0, 16'h0000, 1'b0, 1'b0, 3'd0, 1'b0);

    // Basic download, table driven.
    for (int i = 0; i < 3; i++) begin
      idle(vecs[i].gap);
      send_byte(vecs[i].hi, 1'b0);
      idle(vecs[i].gap);
      send_byte(vecs[i].lo, 1'b0);
      check_outs($sformatf("basic%0d", i), vecs[i].en, vecs[i].inst, vecs[i].done,
                 vecs[i].enable, vecs[i].cnt, vecs[i].err);
    end
    step();
    check_outs("done_once", 1'b0, 16'hABCD, 1'b0, 1'b1, 3'd2, 1'b0);

    // Reload with a simultaneous byte: byte ignored.
    bus.reload   = 1'b1;
    bus.rx_data  = 8'h11;
    bus.rx_valid = 1'b1;
    step();
    bus.reload   = 1'b0;
    bus.rx_valid = 1'b0;
    check_outs("reload", 1'b0, 16'hABCD, 1'b0, 1'b0, 3'd0, 1'b0);
    send_byte(8'h22, 1'b0);
    send_byte(8'h33, 1'b0);
    check_outs("reload_w", 1'b1, 16'h2233, 1'b0, 1'b0, 3'd1, 1'b0);
    send_byte(8'hFF, 1'b0);
    send_byte(8'hFF, 1'b0);
    check_outs("reload_done", 1'b0, 16'h2233, 1'b1, 1'b1, 3'd1, 1'b0);

    // Error on the low byte wins over rx_valid.
    pulse_reload();
    send_byte(8'h77, 1'b0);
    send_byte(8'h88, 1'b1);
    check_outs("errprec", 1'b0, 16'h2233, 1'b0, 1'b0, 3'd0, 1'b1);
    send_byte(8'h99, 1'b0);
    send_byte(8'hAA, 1'b0);
    check_outs("errprec_w", 1'b1, 16'h99AA, 1'b0, 1'b0, 3'd1, 1'b1);
    send_byte(8'hFF, 1'b0);
    send_byte(8'hFF, 1'b0);
    check_outs("errprec_done", 1'b0, 16'h99AA, 1'b1, 1'b1, 3'd1, 1'b1);

    // Timeout: a low byte on the last allowed cycle is still accepted.
    pulse_reload();
    send_byte(8'h55, 1'b0);
    idle(BYTE_TIMEOUT - 1);
    send_byte(8'h66, 1'b0);
    check_outs("to_accept", 1'b1, 16'h5566, 1'b0, 1'b0, 3'd1, 1'b0);
    // One cycle later it expires.
    send_byte(8'h55, 1'b0);
    idle(BYTE_TIMEOUT - 1);
    check_outs("to_pre", 1'b0, 16'h5566, 1'b0, 1'b0, 3'd1, 1'b0);
    step();
    check_outs("to_fire", 1'b0, 16'h5566, 1'b0, 1'b0, 3'd1, 1'b1);
    idle(10);
    send_byte(8'h01, 1'b0);
    send_byte(8'h02, 1'b0);
    check_outs("to_next", 1'b1, 16'h0102, 1'b0, 1'b0, 3'd2, 1'b1);
    send_byte(8'hFF, 1'b0);
    send_byte(8'hFF, 1'b0);
    check_outs("to_done", 1'b0, 16'h0102, 1'b1, 1'b1, 3'd2, 1'b1);

    // MAX_INST limit with back-to-back bytes.
    pulse_reload();
    last_w = 16'h0102;
    for (int i = 0; i < 8; i++) begin
      w = {8'(i + 1), 8'(8'h10 + i)};
      send_byte(w[15:8], 1'b0);
      send_byte(w[7:0], 1'b0);
      if (i < 4) begin
        last_w = w;
        check_outs($sformatf("max%0d", i), 1'b1, w, (i == 3), (i == 3), 3'(i + 1), 1'b0);
      end else begin
        check_outs($sformatf("max%0d", i), 1'b0, last_w, 1'b0, 1'b1, 3'd4, 1'b0);
      end
    end

    // Error strobe in S_HI, reload ignored outside S_DONE, then reset mid-download.
    pulse_reload();
    bus.rx_err = 1'b1;
    step();
    bus.rx_err = 1'b0;
    check_outs("hi_err", 1'b0, 16'h0413, 1'b0, 1'b0, 3'd0, 1'b1);
    pulse_reload();
    check_outs("reload_ign", 1'b0, 16'h0413, 1'b0, 1'b0, 3'd0, 1'b1);
    send_byte(8'h5A, 1'b0);
    reset = 1'b0;
    step();
    reset = 1'b1;
    check_outs("midreset", 1'b0, 16'h0000, 1'b0, 1'b0, 3'd0, 1'b0);
    send_byte(8'h0A, 1'b0);
    send_byte(8'h0B, 1'b0);
    check_outs("after_reset", 1'b1, 16'h0A0B, 1'b0, 1'b0, 3'd1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_inst_loader.md
# uart_inst_loader

Front end of instruction download. It assembles 16-bit instruction words from the UART receiver's byte stream, high byte first. Each completed word goes to the program-counter/fetch stage as a one-cycle `uart_inst_en` strobe with `uart_inst`. When the download ends, it signals `done` and raises the CPU run `enable`. It sits between the UART RX byte receiver and the program counter.

## Interface
- `MAX_INST`, default 256: maximum words per download; reaching it ends the download.
- `END_WORD`, default 16'hFFFF: terminator word; it is consumed and never forwarded.
- `BYTE_TIMEOUT`, default 100000: clk cycles allowed between a high byte and its low byte.
- `clk`  in  1: single clock; all logic on the rising edge.
- `reset`  in  1: synchronous, active-low reset.
- `rx_data`  in  8: received byte.
- `rx_valid`  in  1: one-cycle strobe; `rx_data` is valid.
- `rx_err`  in  1: one-cycle framing/parity error strobe from the UART RX.
- `reload`  in  1: one-cycle request to start a new download; honoured only in S_DONE.
- `uart_inst`  out  16: last assembled word; held until the next word completes.
- `uart_inst_en`  out  1: one-cycle strobe; `uart_inst` is a new instruction.
- `done`  out  1: one-cycle pulse on download completion.
- `enable`  out  1: CPU run enable; low while downloading, high in S_DONE.
- `inst_count`  out  $clog2(MAX_INST+1): number of words forwarded in the current download.
- `err`  out  1: sticky; a byte pair was dropped. Cleared by reset or an accepted `reload`.

## Operation
- States:
  - S_HI: awaiting the high byte.
  - S_LO: awaiting the low byte.
  - S_DONE: CPU running; RX bytes are ignored.
- S_HI:
  - `rx_valid` and no `rx_err`: latch `rx_data` as the high byte, clear the timeout counter, go to S_LO.
  - `rx_err`: set `err`, stay in S_HI.
- S_LO:
  - `rx_valid` and no `rx_err`: form the word {hi, rx_data} and go to S_HI.
  - If the word equals END_WORD: go to S_DONE instead; no strobe, count unchanged.
  - Otherwise: drive `uart_inst` to the word, pulse `uart_inst_en`, increment `inst_count`.
  - If the increment makes `inst_count` equal MAX_INST: go to S_DONE.
  - `rx_err`: drop the high byte, set `err`, go to S_HI.
  - Timeout counter reaches BYTE_TIMEOUT-1 with no byte: drop the high byte, set `err`, go to S_HI.
- Entering S_DONE: `done` pulses for one cycle; `enable`=1 from the same cycle.
- S_DONE with `reload`=1:
  - Go to S_HI; `enable`=0.
  - Clear `inst_count` and `err`.
  - `uart_inst` keeps its value.
- `reload` outside S_DONE is ignored.
- Width rules:
  - `inst_count` saturates at MAX_INST and never wraps.
  - The timeout counter is $clog2(BYTE_TIMEOUT) wide and runs only in S_LO.

## Timing
- Reset values:
  - `uart_inst`=0, `uart_inst_en`=0, `done`=0, `enable`=0, `inst_count`=0, `err`=0.
  - State = S_HI; timeout counter = 0.
- Latency: low byte `rx_valid` in cycle N gives `uart_inst_en`=1 and the new `uart_inst` in cycle N+1.
- Download end:
  - END_WORD low byte in cycle N gives `done`=1 and `enable`=1 in cycle N+1.
  - MAX_INST-th word: `uart_inst_en` and `done` are both high in the same cycle N+1.
- Simultaneous events:
  - `rx_valid` with `rx_err`: the error wins and the byte is discarded.
  - `rx_valid` on the timeout cycle: the byte is accepted and no timeout occurs.
  - `reload` together with `rx_valid` in S_DONE: reload is taken and the byte is ignored.
- Minimum byte spacing is 1 cycle; back-to-back `rx_valid` must be handled without loss.
- Reset mid-download: everything returns to reset values and the partial byte is discarded.

## Structure
- Shared package `cpu_loader_pkg`:
  - state enum `loader_state_t` (S_HI, S_LO, S_DONE);
  - `LOADER_END_WORD` constant (16'hFFFF);
  - `INST_W` = 16.
- Sub-module `loader_timeout`: a loadable down-counter with clear and expire outputs. It is instantiated once and cleared on high-byte accept.
- Total RTL: top FSM plus datapath at about 150–250 lines, plus the counter.

## Test plan
- **Basic download.** Bytes 12 34 AB CD FF FF, spaced 10 cycles.
  - `uart_inst_en` pulses twice, with 16'h1234 then 16'hABCD, each one cycle after its low byte.
  - `done` pulses once; `enable`=1; `inst_count`=2; `err`=0.
- **MAX_INST limit.** MAX_INST=4, 8 words back-to-back (1-cycle spacing).
  - Exactly 4 strobes; `done` coincides with the 4th strobe.
  - Remaining bytes are ignored; `inst_count`=4.
- **Timeout.** BYTE_TIMEOUT=50; high byte 0x55, silence for 60 cycles, then 01 02.
  - `err`=1; the 0x55 byte is dropped.
  - The next strobe carries 16'h0102.
- **Error precedence.** `rx_err` together with `rx_valid` on the low byte of 77 88, then 99 AA.
  - No strobe for 0x7788; `err`=1; the next strobe carries 16'h99AA.
- **Reload.** After `done`, pulse `reload` together with `rx_valid`=0x11, then send 22 33 FF FF.
  - `enable` drops the next cycle; `err` and `inst_count` are cleared.
  - The first word is 16'h2233 (0x11 ignored); `done` pulses again.
- **Reset mid-download.** Assert `reset` low for 1 cycle just after a high byte.
  - All outputs return to reset values.
  - Following bytes 0A 0B give 16'h0A0B.
